// File: rtl/gather_requant_packer_pkg.sv
// Shared widths, saturation bounds and requant configuration type for the
// gather requantizer/packer.
package gather_requant_packer_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int SAT_MAX        = 127;
    localparam int SAT_MIN        = -128;

    typedef struct packed {
        logic [4:0]  shift;
        logic        relu_en;
        logic [15:0] words_per_kernel;
    } requant_cfg_t;
endpackage

// File: rtl/gather_requant_packer_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO; head entry is visible whenever not empty.
module sync_fifo_fwft #(
    parameter int DATA_W = 33,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push, w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_do_push = push & (~full | w_do_pop);
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk)
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/gather_requant_packer.sv
// Bias add, rounding shift, ReLU and int8 saturation on the gather output
// stream; packs four results per word into an output FIFO.
module gather_requant_packer
    import gather_requant_packer_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
    parameter int NO_OF_KERNEL = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int KIDX_WIDTH   = $clog2(NO_OF_KERNEL)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [4:0]                   cfg_shift,
    input  logic                         cfg_relu_en,
    input  logic [15:0]                  cfg_words_per_kernel,
    input  logic                         cfg_clear,
    input  logic                         bias_wr_en,
    input  logic [KIDX_WIDTH-1:0]        bias_wr_addr,
    input  logic signed [DATA_WIDTH-1:0] bias_wr_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [4*OUT_WIDTH-1:0]       m_data,
    output logic                         m_last,
    output logic                         overflow,
    output logic [KIDX_WIDTH-1:0]        kernel_idx
);
    localparam int SW    = DATA_WIDTH + 2;
    localparam int LANES = 4;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [SW:0] L_SMAX = (SW+1)'(SAT_MAX);
    localparam logic signed [SW:0] L_SMIN = (SW+1)'(SAT_MIN);

    requant_cfg_t w_cfg;
    assign w_cfg = '{shift: cfg_shift, relu_en: cfg_relu_en, words_per_kernel: cfg_words_per_kernel};

    logic signed [DATA_WIDTH-1:0]        r_bias [NO_OF_KERNEL];
    logic [15:0]                         r_sample_cnt;
    logic [KIDX_WIDTH-1:0]               r_kidx;
    logic [1:0]                          r_vld_pipe;
    logic signed [SW-1:0]                r_sum;
    logic                                r_last1, r_last2;
    logic signed [OUT_WIDTH-1:0]         r_res;
    logic [LANES-1:0][OUT_WIDTH-1:0]     r_pack;
    logic [1:0]                          r_lane;
    logic                                r_overflow;

    logic [15:0]                         w_wpk_m1;
    logic                                w_s1_last;
    logic signed [SW:0]                  w_rnd, w_shr;
    logic signed [OUT_WIDTH-1:0]         w_sat;
    logic [LANES-1:0][OUT_WIDTH-1:0]     w_word;
    logic                                w_push, w_pop, w_full, w_empty;
    logic [CW-1:0]                       w_count;
    logic [LANES*OUT_WIDTH:0]            w_head;

    assign w_wpk_m1  = (w_cfg.words_per_kernel == '0) ? 16'd0 : w_cfg.words_per_kernel - 16'd1;
    assign w_s1_last = (r_sample_cnt == w_wpk_m1);

    always_comb begin
        w_rnd = (SW+1)'(r_sum);
        if (w_cfg.shift != '0)
            w_rnd = w_rnd + ((SW+1)'(1) << (w_cfg.shift - 5'd1));
        w_shr = w_rnd >>> w_cfg.shift;
        if (w_cfg.relu_en && w_shr[SW]) w_shr = '0;
        if (w_shr > L_SMAX)      w_sat = OUT_WIDTH'(SAT_MAX);
        else if (w_shr < L_SMIN) w_sat = OUT_WIDTH'(SAT_MIN);
        else                     w_sat = w_shr[OUT_WIDTH-1:0];
    end

    // Lanes above the one being written are left 0 so a short final word is zero-padded.
    always_comb begin
        w_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(r_lane))       w_word[i] = r_pack[i];
            else if (i == int'(r_lane)) w_word[i] = r_res;
        end
    end

    assign w_push = r_vld_pipe[1] & ((r_lane == 2'd3) | r_last2);
    assign w_pop  = ~w_empty & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NO_OF_KERNEL; k++) r_bias[k] <= '0;
        end else if (bias_wr_en) begin
            r_bias[bias_wr_addr] <= bias_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0; r_sample_cnt <= '0; r_kidx <= '0;
            r_sum <= '0; r_last1 <= 1'b0; r_res <= '0; r_last2 <= 1'b0;
            r_pack <= '0; r_lane <= '0; r_overflow <= 1'b0;
        end else if (cfg_clear) begin
            r_vld_pipe <= '0; r_sample_cnt <= '0; r_kidx <= '0;
            r_sum <= '0; r_last1 <= 1'b0; r_res <= '0; r_last2 <= 1'b0;
            r_pack <= '0; r_lane <= '0; r_overflow <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], in_valid};
            if (in_valid) begin
                r_sum   <= SW'(in_data) + SW'(r_bias[r_kidx]);
                r_last1 <= w_s1_last;
                if (w_s1_last) begin
                    r_sample_cnt <= '0;
                    r_kidx <= (r_kidx == KIDX_WIDTH'(NO_OF_KERNEL - 1)) ? '0 : r_kidx + 1'b1;
                end else begin
                    r_sample_cnt <= r_sample_cnt + 16'd1;
                end
            end
            if (r_vld_pipe[0]) begin
                r_res   <= w_sat;
                r_last2 <= r_last1;
            end
            if (r_vld_pipe[1]) begin
                if (w_push) begin
                    r_lane <= '0;
                    r_pack <= '0;
                end else begin
                    r_lane         <= r_lane + 2'd1;
                    r_pack[r_lane] <= r_res;
                end
            end
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .DATA_W (LANES*OUT_WIDTH + 1),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cfg_clear),
        .push      (w_push),
        .push_data ({r_last2, w_word}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign m_valid    = (w_count != '0);
    assign m_data     = w_head[LANES*OUT_WIDTH-1:0];
    assign m_last     = w_head[LANES*OUT_WIDTH];
    assign overflow   = r_overflow;
    assign kernel_idx = r_kidx;
endmodule
